dispensador_garrafas: RTL

Bottle dispenser at the consuming end of the dozen-packing line. It accepts one-cycle full-box pulses (`DUZIA_IN`, driven by the bottle counter's dozen-complete output), holds the boxes in a bounded stock, and opens one box at a time. It then releases bottles one per accepted request until the box is empty. In effect it is the unpacking counterpart of the 0–12 up-counter: it loads `BOX_SIZE` and counts down.

---
 rtl/dispensador_garrafas.sv | 105 ++++++++++
 1 files changed

// File: rtl/dispensador_garrafas.sv
// rtl/dispensador_garrafas.sv - bottle dispenser: boxes held in bounded stock, opened one at a time, bottles counted down
module dispensador_garrafas #(
    parameter int BOX_SIZE  = 12,
    parameter int MAX_BOXES = 7
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       DUZIA_IN,
    input  logic       PEDIDO,
    output logic       PRONTO,
    output logic       GARRAFA_OUT,
    output logic [3:0] GARRAFAS_RESTANTES,
    output logic [2:0] CAIXAS_ESTOQUE,
    output logic       ESTOQUE_CHEIO,
    output logic       FALTA,
    output logic       PERDA
);

    localparam logic [3:0] BOX_LOAD  = 4'(BOX_SIZE);
    localparam logic [2:0] STOCK_MAX = 3'(MAX_BOXES);

    typedef enum logic [1:0] {
        VAZIO,
        ABRINDO,
        SERVINDO
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] remaining;
    logic [3:0] remaining_next;
    logic [2:0] stock;
    logic [2:0] stock_next;
    logic       bottle_next;
    logic       perda_next;
    logic       opening;
    logic       fire;
    logic       drop;
    logic       arrival;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= VAZIO;
            remaining   <= 4'd0;
            stock       <= 3'd0;
            GARRAFA_OUT <= 1'b0;
            PERDA       <= 1'b0;
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            stock       <= stock_next;
            GARRAFA_OUT <= bottle_next;
            PERDA       <= perda_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        stock_next     = stock;
        opening        = (state == ABRINDO);
        fire           = PEDIDO && (state == SERVINDO);
        // an arrival at full stock is only absorbed when a box leaves stock the same cycle
        drop           = DUZIA_IN && (stock == STOCK_MAX) && !opening;
        arrival        = DUZIA_IN && !drop;
        bottle_next    = fire;
        perda_next     = drop;

        if (arrival && !opening) begin
            stock_next = stock + 3'd1;
        end else if (!arrival && opening) begin
            stock_next = stock - 3'd1;
        end

        case (state)
            VAZIO: begin
                if (stock != 3'd0) begin
                    state_next = ABRINDO;
                end
            end
            ABRINDO: begin
                remaining_next = BOX_LOAD;
                state_next     = SERVINDO;
            end
            SERVINDO: begin
                if (fire) begin
                    remaining_next = remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        state_next = VAZIO;
                    end
                end
            end
            default: begin
                state_next = VAZIO;
            end
        endcase
    end

    assign PRONTO             = (state == SERVINDO);
    assign GARRAFAS_RESTANTES = remaining;
    assign CAIXAS_ESTOQUE     = stock;
    assign ESTOQUE_CHEIO      = (stock == STOCK_MAX);
    assign FALTA              = (state == VAZIO) && (stock == 3'd0);

endmodule
